f3_move_sequencer: RTL and testbench

Command sequencer for function 3, the sliding-tile puzzle. It consumes the level-style `write`/`instruction` stream from the function-3 key processor and turns each new key press into a legal blank-tile move on a 4x4 board. A Scramble press becomes a burst of pseudo-random legal moves. It owns the authoritative board state and mirrors every tile change to the display's board memory over a simple write port.

---
 rtl/f3_pkg.sv | 72 +++++++
 rtl/f3_lfsr16.sv | 27 ++
 rtl/f3_move_sequencer.sv | 145 ++++++++++++++
 tb/tb_f3_move_sequencer.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/f3_pkg.sv
// Shared constants, types and helpers for the function-3 sliding-tile sequencer.
package f3_pkg;

  localparam int BOARD_DIM = 4;
  localparam int CELL_W    = 4;

  typedef logic [15:0][CELL_W-1:0] board_t;

  // Key-processor instruction codes
  localparam logic [3:0] INS_NONE     = 4'd0;
  localparam logic [3:0] INS_NORTH    = 4'd1;
  localparam logic [3:0] INS_EAST     = 4'd2;
  localparam logic [3:0] INS_WEST     = 4'd3;
  localparam logic [3:0] INS_SOUTH    = 4'd4;
  localparam logic [3:0] INS_SCRAMBLE = 4'd5;

  // Blank-motion directions; the encoding matches the LFSR pick bits
  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_W = 2'd2;
  localparam logic [1:0] DIR_S = 2'd3;

  // Sequencer states
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CHECK    = 3'd1;
  localparam logic [2:0] ST_REJECT   = 3'd2;
  localparam logic [2:0] ST_SCR_PICK = 3'd3;
  localparam logic [2:0] ST_WR_BLANK = 3'd4;
  localparam logic [2:0] ST_WR_TILE  = 3'd5;

  // Solved image: cell i holds i+1, last cell is the blank
  function automatic board_t solved_board();
    board_t b;
    for (int i = 0; i < 16; i++) begin
      b[i] = (i == 15) ? '0 : CELL_W'(i + 1);
    end
    return b;
  endfunction

  // Map a player instruction code onto a blank-motion direction
  function automatic logic [1:0] code_to_dir(input logic [3:0] code);
    logic [1:0] d;
    case (code)
      INS_NORTH: d = DIR_N;
      INS_EAST:  d = DIR_E;
      INS_WEST:  d = DIR_W;
      INS_SOUTH: d = DIR_S;
      default:   d = DIR_N;
    endcase
    return d;
  endfunction

  // Returns {legal, neighbour cell} for moving the blank at pos in direction dir
  function automatic logic [4:0] move_target(input logic [3:0] pos, input logic [1:0] dir);
    logic [1:0] row;
    logic [1:0] col;
    logic       ok;
    logic [3:0] tgt;
    row = pos[3:2];
    col = pos[1:0];
    ok  = 1'b0;
    tgt = pos;
    case (dir)
      DIR_N: begin ok = (row != 2'd0);              tgt = pos - 4'd4; end
      DIR_E: begin ok = (col != 2'(BOARD_DIM - 1)); tgt = pos + 4'd1; end
      DIR_W: begin ok = (col != 2'd0);              tgt = pos - 4'd1; end
      default: begin ok = (row != 2'(BOARD_DIM - 1)); tgt = pos + 4'd4; end
    endcase
    return {ok, tgt};
  endfunction

endpackage

// File: rtl/f3_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used to pick scramble moves.
module f3_lfsr16
  import f3_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       sysclk,
  input  logic       reset,
  output logic [1:0] pick
);

  logic [15:0] lfsr;
  logic        feedback;

  assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign pick     = lfsr[1:0];

  // Advance every cycle so that key-press timing feeds the random stream
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {lfsr[14:0], feedback};
    end
  end

endmodule

// File: rtl/f3_move_sequencer.sv
// Turns function-3 key presses into legal blank moves on a 4x4 board and mirrors
// every tile change to the display board memory as a blank-write/tile-write pair.
module f3_move_sequencer
  import f3_pkg::*;
#(
  parameter int          SCRAMBLE_MOVES = 64,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        write,
  input  logic [3:0]  instruction,
  output logic        bw_en,
  output logic [3:0]  bw_addr,
  output logic [3:0]  bw_data,
  output logic [3:0]  blank_pos,
  output logic        busy,
  output logic        done,
  output logic        reject,
  output logic [15:0] move_count
);

  logic [2:0] state;
  logic [1:0] dir;
  logic [3:0] nbr;
  logic       scr;
  logic [9:0] remaining;
  logic       prev_write;
  logic [3:0] prev_instr;
  board_t     board;

  logic [1:0] lfsr_pick;
  logic [1:0] pick_dir;
  logic [4:0] target;
  logic       press;

  f3_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .sysclk (sysclk),
    .reset  (reset),
    .pick   (lfsr_pick)
  );

  // A new press is a valid code with either a fresh write or a changed code
  assign press = write && (instruction != INS_NONE) && (instruction <= INS_SCRAMBLE) &&
                 (!prev_write || (instruction != prev_instr));

  assign pick_dir = (state == ST_SCR_PICK) ? lfsr_pick : dir;
  assign target   = move_target(blank_pos, pick_dir);

  // Command FSM, board image and registered mirror-port outputs
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      dir        <= DIR_N;
      nbr        <= '0;
      scr        <= 1'b0;
      remaining  <= '0;
      prev_write <= 1'b0;
      prev_instr <= INS_NONE;
      board      <= solved_board();
      blank_pos  <= 4'd15;
      bw_en      <= 1'b0;
      bw_addr    <= '0;
      bw_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      reject     <= 1'b0;
      move_count <= '0;
    end else begin
      prev_write <= write;
      prev_instr <= instruction;
      bw_en      <= 1'b0;
      bw_addr    <= '0;
      bw_data    <= '0;
      done       <= 1'b0;
      reject     <= 1'b0;
      case (state)
        ST_IDLE: begin
          busy <= press;
          if (press) begin
            if (instruction == INS_SCRAMBLE) begin
              state      <= ST_SCR_PICK;
              scr        <= 1'b1;
              remaining  <= 10'(SCRAMBLE_MOVES);
              move_count <= '0;
            end else begin
              state <= ST_CHECK;
              scr   <= 1'b0;
              dir   <= code_to_dir(instruction);
            end
          end
        end
        ST_CHECK: begin
          if (target[4]) begin
            nbr   <= target[3:0];
            state <= ST_WR_BLANK;
          end else begin
            state <= ST_REJECT;
          end
        end
        ST_REJECT: begin
          reject <= 1'b1;
          state  <= ST_IDLE;
        end
        ST_SCR_PICK: begin
          if (target[4]) begin
            nbr   <= target[3:0];
            state <= ST_WR_BLANK;
          end
        end
        ST_WR_BLANK: begin
          bw_en            <= 1'b1;
          bw_addr          <= blank_pos;
          bw_data          <= board[nbr];
          board[blank_pos] <= board[nbr];
          state            <= ST_WR_TILE;
        end
        ST_WR_TILE: begin
          bw_en      <= 1'b1;
          bw_addr    <= nbr;
          bw_data    <= '0;
          board[nbr] <= '0;
          blank_pos  <= nbr;
          if (!scr) begin
            if (move_count != 16'hFFFF) begin
              move_count <= move_count + 16'd1;
            end
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            remaining <= remaining - 10'd1;
            if (remaining == 10'd1) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              state <= ST_SCR_PICK;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_f3_move_sequencer.sv
// Self-checking bench for f3_move_sequencer: a board-level model tracks the
// expected tile image, blank and move counter from the puzzle rules.
module tb_f3_move_sequencer;

  localparam int N_SCR = 8;

  logic        sysclk = 1'b0;
  logic        reset;
  logic        write;
  logic [3:0]  instruction;
  logic        bw_en;
  logic [3:0]  bw_addr;
  logic [3:0]  bw_data;
  logic [3:0]  blank_pos;
  logic        busy;
  logic        done;
  logic        reject;
  logic [15:0] move_count;

  f3_move_sequencer #(.SCRAMBLE_MOVES(N_SCR), .LFSR_SEED(16'hACE1)) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .write       (write),
    .instruction (instruction),
    .bw_en       (bw_en),
    .bw_addr     (bw_addr),
    .bw_data     (bw_data),
    .blank_pos   (blank_pos),
    .busy        (busy),
    .done        (done),
    .reject      (reject),
    .move_count  (move_count)
  );

  // 100 MHz-style free-running clock
  always #5 sysclk = ~sysclk;

  int checks   = 0;
  int failures = 0;

  // Model state
  int mb [16];
  int mblank;
  int mcount;
  bit mon_en    = 1'b0;
  bit phase     = 1'b0;
  bit scr_mode  = 1'b0;
  bit exp_done;
  int scr_target;
  int pairs;
  int exp_nbr;
  int first_data;
  int done_cnt = 0;
  int rej_cnt  = 0;
  int bw_cnt   = 0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Where the blank lands for a player code, or -1 when it would leave the board
  function automatic int model_target(input int blank, input int code);
    int r;
    int c;
    r = blank / 4;
    c = blank % 4;
    case (code)
      1: r = r - 1;
      2: c = c + 1;
      3: c = c - 1;
      4: r = r + 1;
      default: return -1;
    endcase
    if (r < 0 || r > 3 || c < 0 || c > 3) return -1;
    return r * 4 + c;
  endfunction

  function automatic int is_adj(input int a, input int b);
    int dr;
    int dc;
    dr = (a / 4) - (b / 4);
    dc = (a % 4) - (b % 4);
    if (dr < 0) dr = -dr;
    if (dc < 0) dc = -dc;
    return (dr + dc == 1) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mb[i] = (i < 15) ? i + 1 : 0;
    mblank = 15;
    mcount = 0;
    phase  = 1'b0;
    pairs  = 0;
  endtask

  // Per-cycle comparison of mirror writes, done, blank and counter against the model
  always @(negedge sysclk) begin
    if (mon_en) begin
      exp_done = 1'b0;
      if (bw_en === 1'b1) begin
        bw_cnt++;
        if (!phase) begin
          check_output("pair_first_addr", bw_addr, mblank);
          first_data = bw_data;
          phase = 1'b1;
        end else begin
          check_output("pair_adjacent", is_adj(mblank, bw_addr), 1);
          if (!scr_mode) check_output("pair_player_nbr", bw_addr, exp_nbr);
          check_output("pair_second_data", bw_data, 0);
          check_output("pair_moved_tile", first_data, mb[bw_addr]);
          mb[mblank]  = mb[bw_addr];
          mb[bw_addr] = 0;
          mblank      = bw_addr;
          phase       = 1'b0;
          pairs++;
          if (scr_mode) begin
            exp_done = (pairs == scr_target);
          end else begin
            exp_done = 1'b1;
            if (mcount < 65535) mcount++;
          end
        end
      end else if (phase) begin
        check_output("pair_second_write", bw_en, 1);
        phase = 1'b0;
      end
      check_output("done", done, exp_done);
      check_output("blank_pos", blank_pos, mblank);
      check_output("move_count", move_count, mcount);
      if (done === 1'b1) done_cnt++;
      if (reject === 1'b1) rej_cnt++;
    end
  end

  task automatic tick();
    @(posedge sysclk);
    #2;
  endtask

  task automatic do_reset();
    mon_en      = 1'b0;
    write       = 1'b0;
    instruction = 4'd0;
    reset       = 1'b1;
    tick();
    tick();
    model_reset();
    reset = 1'b0;
    tick();
    mon_en = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 500) begin
      tick();
      n++;
    end
    check_output("idle_reached", busy, 0);
    tick();
  endtask

  // Press a code for hold cycles, release, wait for idle and check event counts
  task automatic apply_stimulus(input logic [3:0] code, input int hold);
    int d0;
    int r0;
    int b0;
    int tgt;
    d0 = done_cnt;
    r0 = rej_cnt;
    b0 = bw_cnt;
    tgt = 0;
    if (code == 4'd5) begin
      scr_mode   = 1'b1;
      scr_target = N_SCR;
      pairs      = 0;
    end else begin
      scr_mode = 1'b0;
      tgt      = model_target(mblank, code);
      exp_nbr  = tgt;
    end
    write       = 1'b1;
    instruction = code;
    tick();
    if (code == 4'd5) mcount = 0;
    for (int i = 1; i < hold; i++) tick();
    write       = 1'b0;
    instruction = 4'd0;
    wait_idle();
    if (code == 4'd5) begin
      check_output("scr_done_count", done_cnt - d0, 1);
      check_output("scr_bw_cycles", bw_cnt - b0, 2 * N_SCR);
      check_output("scr_reject_count", rej_cnt - r0, 0);
    end else if (tgt >= 0) begin
      check_output("move_done_count", done_cnt - d0, 1);
      check_output("move_bw_cycles", bw_cnt - b0, 2);
      check_output("move_reject_count", rej_cnt - r0, 0);
    end else begin
      check_output("illegal_done_count", done_cnt - d0, 0);
      check_output("illegal_bw_cycles", bw_cnt - b0, 0);
      check_output("illegal_reject_count", rej_cnt - r0, 1);
    end
    scr_mode = 1'b0;
  endtask

  // North from the solved board with cycle-exact hand-computed expectations
  task automatic north_from_reset();
    int d0;
    int b0;
    d0 = done_cnt;
    b0 = bw_cnt;
    scr_mode    = 1'b0;
    exp_nbr     = 11;
    write       = 1'b1;
    instruction = 4'd1;
    tick();
    check_output("n_e0_busy", busy, 1);
    check_output("n_e0_bw_en", bw_en, 0);
    tick();
    check_output("n_e1_bw_en", bw_en, 0);
    tick();
    check_output("n_e2_bw_en", bw_en, 1);
    check_output("n_e2_addr", bw_addr, 15);
    check_output("n_e2_data", bw_data, 12);
    check_output("n_e2_done", done, 0);
    tick();
    check_output("n_e3_bw_en", bw_en, 1);
    check_output("n_e3_addr", bw_addr, 11);
    check_output("n_e3_data", bw_data, 0);
    check_output("n_e3_done", done, 1);
    check_output("n_e3_blank", blank_pos, 11);
    check_output("n_e3_count", move_count, 1);
    check_output("n_e3_busy", busy, 1);
    tick();
    check_output("n_e4_busy", busy, 0);
    check_output("n_e4_bw_en", bw_en, 0);
    check_output("n_e4_done", done, 0);
    for (int i = 0; i < 5; i++) tick();
    write       = 1'b0;
    instruction = 4'd0;
    tick();
    check_output("n_bw_cycles", bw_cnt - d0 * 0 - b0, 2);
    check_output("n_done_count", done_cnt - d0, 1);
    check_output("n_blank", blank_pos, 11);
    check_output("n_count", move_count, 1);
  endtask

  // Bound the whole run
  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int mask;
    int d0;
    int b0;
    int r0;

    write       = 1'b0;
    instruction = 4'd0;
    reset       = 1'b1;
    #1;
    check_output("rst_blank", blank_pos, 15);
    check_output("rst_busy", busy, 0);
    check_output("rst_bw_en", bw_en, 0);
    check_output("rst_count", move_count, 0);
    do_reset();

    // Reset then North held 10 cycles
    north_from_reset();

    // Illegal East from the solved board
    do_reset();
    r0 = rej_cnt;
    b0 = bw_cnt;
    write       = 1'b1;
    instruction = 4'd2;
    tick();
    check_output("e_e0_busy", busy, 1);
    tick();
    check_output("e_e1_reject", reject, 0);
    tick();
    check_output("e_e2_reject", reject, 1);
    check_output("e_e2_busy", busy, 1);
    tick();
    check_output("e_e3_reject", reject, 0);
    check_output("e_e3_busy", busy, 0);
    write       = 1'b0;
    instruction = 4'd0;
    tick();
    check_output("e_reject_count", rej_cnt - r0, 1);
    check_output("e_bw_cycles", bw_cnt - b0, 0);
    check_output("e_blank", blank_pos, 15);
    check_output("e_count", move_count, 0);

    // North held, switched to West without releasing: two moves
    do_reset();
    d0 = done_cnt;
    scr_mode    = 1'b0;
    exp_nbr     = 11;
    write       = 1'b1;
    instruction = 4'd1;
    for (int i = 0; i < 6; i++) tick();
    exp_nbr     = 10;
    instruction = 4'd3;
    for (int i = 0; i < 6; i++) tick();
    write       = 1'b0;
    instruction = 4'd0;
    tick();
    check_output("hold_done_count", done_cnt - d0, 2);
    check_output("hold_blank", blank_pos, 10);
    check_output("hold_count", move_count, 2);

    // A different code pressed while busy is dropped, even when held afterwards
    d0 = done_cnt;
    b0 = bw_cnt;
    exp_nbr     = 6;
    write       = 1'b1;
    instruction = 4'd1;
    tick();
    instruction = 4'd3;
    for (int i = 0; i < 8; i++) tick();
    write       = 1'b0;
    instruction = 4'd0;
    tick();
    check_output("busy_drop_done", done_cnt - d0, 1);
    check_output("busy_drop_bw", bw_cnt - b0, 2);
    check_output("busy_drop_blank", blank_pos, 6);

    // Scramble burst, then one player move from the scrambled board
    apply_stimulus(4'd5, 1);
    check_output("scr_count", move_count, 0);
    mask = 0;
    for (int i = 0; i < 16; i++) begin
      check_output("scr_board_cell", dut.board[i], mb[i]);
      mask = mask | (1 << int'(dut.board[i]));
    end
    check_output("scr_permutation", mask, 32'h0000FFFF);
    for (int c = 1; c <= 4; c++) begin
      if (model_target(mblank, c) >= 0 && mcount == 0) apply_stimulus(4'(c), 2);
    end
    check_output("post_scr_count", move_count, 1);

    // Reset asserted in the middle of a scramble
    scr_mode    = 1'b1;
    scr_target  = N_SCR;
    pairs       = 0;
    write       = 1'b1;
    instruction = 4'd5;
    tick();
    mcount      = 0;
    write       = 1'b0;
    instruction = 4'd0;
    for (int i = 0; i < 7; i++) tick();
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    check_output("mid_rst_blank", blank_pos, 15);
    check_output("mid_rst_bw_en", bw_en, 0);
    check_output("mid_rst_busy", busy, 0);
    check_output("mid_rst_done", done, 0);
    check_output("mid_rst_count", move_count, 0);
    for (int i = 0; i < 16; i++) check_output("mid_rst_board", dut.board[i], (i < 15) ? i + 1 : 0);
    tick();
    model_reset();
    reset    = 1'b0;
    scr_mode = 1'b0;
    tick();
    mon_en = 1'b1;
    north_from_reset();

    // Saturation of the player move counter
    do_reset();
    force dut.move_count = 16'hFFFE;
    mcount = 65534;
    tick();
    release dut.move_count;
    tick();
    apply_stimulus(4'd1, 1);
    apply_stimulus(4'd1, 1);
    apply_stimulus(4'd4, 1);
    check_output("sat_count", move_count, 16'hFFFF);
    check_output("sat_blank", blank_pos, 11);

    // Illegal move from an edge cell via the generic path
    apply_stimulus(4'd2, 1);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
